// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-cache request/response, decode-side controls and IF/ID outputs.
// The fetch unit takes the master side; the environment (cache, decode) takes the slave side.
interface fetch_unit_if;
    typedef logic [31:0] word_t;

    logic  ihit;
    word_t iload;
    logic  iREN;
    word_t iaddr;
    logic  stall;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    word_t instruction;
    word_t pc_src;
    logic  valid;

    modport master (
        input  ihit, iload, stall, redirect, redirect_pc, halt,
        output iREN, iaddr, instruction, pc_src, valid
    );

    modport slave (
        output ihit, iload, stall, redirect, redirect_pc, halt,
        input  iREN, iaddr, instruction, pc_src, valid
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction fetch: PC, I-cache request and IF/ID register; 1-cycle hit-to-IF/ID latency.
// Stall holds PC and IF/ID; a miss is drained at the old address before a redirect target is used.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input logic        CLK,
    input logic        RST,
    fetch_unit_if.master fif
);
    typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] target;
    logic [31:0] pc_next_seq;

    assign target      = fif.redirect_pc & ~32'h3;
    assign pc_next_seq = pc + 32'd4;

    assign fif.iREN  = (state != HALTED) && !RST;
    assign fif.iaddr = pc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= FETCH;
            pc              <= PC_INIT;
            pend_pc         <= 32'h0;
            fif.instruction <= 32'h0;
            fif.pc_src      <= 32'h0;
            fif.valid       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (fif.halt) begin
                        state           <= HALTED;
                        fif.instruction <= 32'h0;
                        fif.pc_src      <= 32'h0;
                        fif.valid       <= 1'b0;
                    end else if (fif.redirect) begin
                        // Redirect beats stall: the stalled instruction is on the squashed path.
                        if (fif.ihit) begin
                            pc <= target;
                        end else begin
                            pend_pc <= target;
                            state   <= DRAIN;
                        end
                        fif.instruction <= 32'h0;
                        fif.pc_src      <= 32'h0;
                        fif.valid       <= 1'b0;
                    end else if (fif.ihit && !fif.stall) begin
                        fif.instruction <= fif.iload;
                        fif.pc_src      <= pc_next_seq;
                        fif.valid       <= 1'b1;
                        pc              <= pc_next_seq;
                    end
                end
                DRAIN: begin
                    // The outstanding miss must complete at the old pc before switching address.
                    if (fif.halt) begin
                        state <= HALTED;
                    end else if (fif.ihit) begin
                        pc    <= fif.redirect ? target : pend_pc;
                        state <= FETCH;
                    end else if (fif.redirect) begin
                        pend_pc <= target;
                    end
                    fif.instruction <= 32'h0;
                    fif.pc_src      <= 32'h0;
                    fif.valid       <= 1'b0;
                end
                HALTED: begin
                end
                default: state <= HALTED;
            endcase
        end
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter and issues word requests to the instruction cache. It latches each returned instruction with its PC+4 into the IF/ID pipeline register, and it handles decode stalls, branch/jump redirects and halt. Its IF/ID outputs drive the `instruction` and `pc_src` inputs of the decode stage.

## Interface

Parameters:
- `PC_INIT`, default 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.

Ports:
- `CLK`, input, 1: single clock. All state updates on the rising edge.
- `RST`, input, 1: reset. Asynchronous and active-high.
- `ihit`, input, 1: the instruction cache returns `iload` for `iaddr` in this cycle.
- `iload`, input, 32: instruction word from the instruction cache.
- `iREN`, output, 1: instruction read request.
- `iaddr`, output, 32: instruction address, word aligned.
- `stall`, input, 1: decode hazard. Hold the PC and the IF/ID register.
- `redirect`, input, 1: branch taken or jump resolved downstream.
- `redirect_pc`, input, 32: redirect target. Bits [1:0] are ignored and forced to 00.
- `halt`, input, 1: a halt instruction has committed. Stop fetching.
- `instruction`, output, 32: IF/ID instruction (`word_t`).
- `pc_src`, output, 32: IF/ID PC+4 of `instruction` (`word_t`).
- `valid`, output, 1: the IF/ID contents are a real instruction, not a bubble.

## Operation

**Registers**
- `pc` (32 bits).
- `pend_pc` (32 bits).
- `state`, one of FETCH, DRAIN, HALTED.
- IF/ID register: `instruction`, `pc_src`, `valid`.

**Bubble**
- A bubble is `instruction`=0 (sll $0 nop), `pc_src`=0, `valid`=0.

**Combinational outputs**
- `iREN` = 1 in FETCH and DRAIN, 0 in HALTED, and 0 while `RST` is high.
- `iaddr` = `pc` in every state.

**FETCH state** (one case applies per cycle, in priority order):
1. `halt`=1: go to HALTED. Load a bubble into IF/ID. `pc` holds. Halt beats every other input.
2. `redirect`=1 and `ihit`=1: `pc` <= target. Load a bubble into IF/ID. The returned word is discarded.
3. `redirect`=1 and `ihit`=0: `pend_pc` <= target. Go to DRAIN. Load a bubble into IF/ID.
4. `ihit`=1 and `stall`=0: IF/ID <= {`iload`, `pc`+4, 1}. `pc` <= `pc`+4.
5. `ihit`=1 and `stall`=1: `pc` and IF/ID hold. The same word is requested again next cycle.
6. `ihit`=0: `pc` and IF/ID hold, whatever `stall` is.

Redirect overrides `stall`, because the stalled instruction lies on the squashed path.

**DRAIN state**
- Keeps the outstanding miss request stable at the old `pc` until the cache completes it.
- IF/ID holds the bubble.
- A new `redirect` overwrites `pend_pc`.
- On `ihit`: the returned word is discarded, `pc` <= `pend_pc`, go to FETCH. If `redirect` is also high that cycle, its target goes straight into `pc`.
- `halt` goes to HALTED from this state too.

**HALTED state**
- Absorbing. Only `RST` leaves it.
- `iREN`=0. All registers hold.

**Arithmetic**
- `pc`+4 is unsigned, 32 bits, and wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing

**Reset values** (`RST` asserted, asynchronous, takes effect at any point in a cycle):
- `pc` = `PC_INIT`, `pend_pc` = 0, `state` = FETCH.
- `instruction` = 0, `pc_src` = 0, `valid` = 0.
- `iREN` = 0 while `RST` is high. `iaddr` = `PC_INIT`.
- Reset in DRAIN or HALTED abandons the pending target.

**Latency**
- On `ihit` with no stall, the instruction appears on the IF/ID outputs on the following clock edge.
- Throughput is 1 instruction per cycle on consecutive hits.

**Redirect**
- The first edge after `redirect` is sampled leaves a bubble in IF/ID.
- With a hit at the time of redirect, `iaddr` shows the target 1 cycle after redirect.
- During a miss, `iaddr` shows the target in the cycle after the drain `ihit`.

**Stall**
- `stall` is sampled every cycle with no memory.
- Outputs are bit-identical across every stalled cycle.

**Cache interaction**
- `iaddr` never changes while `ihit`=0 and `iREN`=1.

## Test plan

1. **Reset and sequential fetch.** Release `RST` with `PC_INIT`=0 and `ihit`=1 every cycle, `iload` = 0x11, 0x22, 0x33. Required: `iaddr` = 0, 4, 8; IF/ID = (0x11, 4, 1), then (0x22, 8, 1), then (0x33, 12, 1).
2. **Stall.** At `pc`=8 with `ihit`=1, hold `stall`=1 for 3 cycles. Required: `iaddr` stays 8 and IF/ID stays (0x22, 8, 1). On release, IF/ID = (0x33, 12, 1).
3. **Redirect on a hit.** At `pc`=0x10, drive `redirect`=1, `redirect_pc`=0x103, `ihit`=1. Required: next cycle `iaddr`=0x100 and `valid`=0. Then with `stall`=1 and `redirect`=1 together, the redirect takes effect.
4. **Redirect during a miss.** With `ihit`=0 at `pc`=0x20, drive `redirect` to 0x40, then `redirect` to 0x80 two cycles later, then `ihit`=1 after 5 cycles. Required: `iaddr` stays 0x20 throughout; the returned word never appears on IF/ID; next `iaddr`=0x80.
5. **Halt.** Assert `halt` in FETCH, and separately in DRAIN. Required: `iREN`=0 and a bubble in IF/ID from the next cycle, and `redirect`/`ihit` are ignored afterwards.
6. **Asynchronous reset and wrap.** Assert `RST` mid-cycle while in DRAIN. Required: outputs return to their reset values immediately, without waiting for `CLK`. Separately, `PC_INIT`=32'hFFFF_FFFC with `ihit`=1 gives `pc_src`=0 and then `iaddr`=0.
